tx: RTL
=======

TX -- requirements
Module: tx

Interface
REQ-001 The block SHALL have parameter routerid, default -1, router index for trace output; values below 0 disable tracing.
REQ-002 The block SHALL have parameter port, default "unknown", port label for trace output.
REQ-003 The block SHALL use data width SIZE, a macro defaulting to 8 when undefined.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 valid_in  input  1  parallel_in holds an item to send.
REQ-007 parallel_in  input  SIZE  item to serialise.
REQ-008 ready  output  1  an item is accepted at any edge where valid_in and ready are both 1.
REQ-009 channel_busy  input  1  far-end receiver busy, high from the start-bit sample until its item is read.
REQ-010 serial_out  output  1  serial line; 0 when idle.
REQ-011 tx_busy  output  1  high when state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, SEND and WAIT.
REQ-013 Frame format SHALL be one start bit of 1, then SIZE data bits LSB first, one bit per clock, with no gaps.
REQ-014 A launch SHALL occur at an edge where state is IDLE, channel_busy is 0 and an item is available; it loads {item,1'b1} into the shift register and enters SEND.
REQ-015 In SEND, serial_out SHALL equal shift register bit 0, and the register SHALL shift right one bit per clock, zero-filling.
REQ-016 SEND SHALL last exactly SIZE+1 cycles, counted by a bit counter of width ceil(log2(SIZE+2)), and then enter WAIT.
REQ-017 In IDLE and WAIT, serial_out SHALL be 0, so the receiver's extra post-frame sample is 0.
REQ-018 WAIT SHALL return to IDLE at the first edge where channel_busy is 0; a launch SHALL NOT occur in that same cycle.
REQ-019 The first start bit SHALL appear on serial_out in the cycle after the launch edge.
REQ-020 With the buffer compiled out, ready SHALL equal (state==IDLE) and not channel_busy, and acceptance SHALL be the launch.
REQ-021 channel_busy rising during SEND SHALL be ignored, because it is the expected receiver response.
REQ-022 channel_busy low throughout SEND SHALL NOT abort the frame; the block still enters WAIT after SEND.
REQ-023 When routerid is 0 or greater, each launch SHALL print "router <id> <port> tx : <item>" in simulation only.

Reset
REQ-024 While reset is asserted, state SHALL be IDLE, and the shift register, counter and buffer SHALL be cleared.
REQ-025 While reset is asserted, serial_out, tx_busy and ready SHALL be 0, asynchronously, including mid-frame.
REQ-026 After reset is released, ready SHALL follow the REQ-020 rule, or the REQ-028 rule when TX_BUF_EN is defined, from the first edge.

Configuration
REQ-027 Macro TX_BUF_EN SHALL compile in a one-entry holding buffer (data register plus full flag).
REQ-028 With TX_BUF_EN defined:
- ready SHALL equal not buf_full;
- an accepted item enters the buffer;
- a launch takes the item from the buffer;
- accept and launch at the same edge SHALL leave the buffer full with the new item.
REQ-029 With TX_BUF_EN defined, the start bit SHALL appear at the earliest two cycles after acceptance.
REQ-030 Without TX_BUF_EN, no buffer logic SHALL exist and REQ-020 SHALL apply.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=0, SEND=1, WAIT=2, 2 bits) and the SIZE default.
REQ-032 The shift register and counter SHALL stay inline; one optional sub-module tx_buf SHALL hold the TX_BUF_EN buffer.

Verification
REQ-033 SIZE=8, parallel_in=0xA5, channel_busy low -> serial_out reads 1,1,0,1,0,0,1,0,1 over 9 cycles, then 0.
REQ-034 Loopback into the matching receiver, items 0x01, 0xFF, 0x80 read immediately -> the receiver outputs the same three values in order; none lost or duplicated.
REQ-035 channel_busy held high for 20 cycles with valid_in=1 -> ready=0 and serial_out=0 throughout; the launch occurs one cycle after channel_busy falls.
REQ-036 reset asserted at bit 4 of a frame -> serial_out, tx_busy and ready go 0 immediately; the next item sends a complete, correct frame.
REQ-037 With TX_BUF_EN, 0x3C and 0xC3 offered back to back -> both accepted (ready low only while the buffer is full); frames are sent in order, each after channel_busy falls.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: state encoding, data width and frame helper shared by the tx slice.
// SIZE is a build macro (default 8).
`ifndef SIZE
`define SIZE 8
`endif

package tx_pkg;

    localparam int TX_SIZE = `SIZE;
    localparam int CNT_W   = $clog2(TX_SIZE + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

    // Start bit of 1 sits in bit 0 so it leaves first.
    function automatic logic [TX_SIZE:0] frame_of(input logic [TX_SIZE-1:0] d);
        return {d, 1'b1};
    endfunction

endpackage

// File: rtl/tx_buf.sv
// tx_buf: one-entry holding buffer in front of the serialiser.
// Only instantiated when TX_BUF_EN is defined.
module tx_buf
    import tx_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [TX_SIZE-1:0] parallel_in,
    input  logic               take,
    output logic               ready,
    output logic               buf_full,
    output logic [TX_SIZE-1:0] buf_data
);

    logic accept;

    assign ready  = !buf_full && !reset;
    assign accept = valid_in && ready;

    // A fresh accept wins over a same-edge take: the buffer stays full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= parallel_in;
        end else if (take) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: rtl/tx.sv
// tx: parallel-to-serial link transmitter (start bit 1, LSB first).
// Define TX_BUF_EN to add a one-entry input buffer (tx_buf).
module tx
    import tx_pkg::*;
#(
    parameter int    routerid = -1,
    parameter string port     = "unknown"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [TX_SIZE-1:0] parallel_in,
    output logic               ready,
    input  logic               channel_busy,
    output logic               serial_out,
    output logic               tx_busy
);

    tx_state_e          state;
    tx_state_e          state_nx;
    logic [TX_SIZE:0]   shreg;
    logic [TX_SIZE:0]   shreg_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               have_item;
    logic [TX_SIZE-1:0] item;
    logic               launch;

`ifdef TX_BUF_EN
    logic               buf_full;
    logic [TX_SIZE-1:0] buf_data;

    tx_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .parallel_in (parallel_in),
        .take        (launch),
        .ready       (ready),
        .buf_full    (buf_full),
        .buf_data    (buf_data)
    );

    assign have_item = buf_full;
    assign item      = buf_data;
`else
    assign have_item = valid_in;
    assign item      = parallel_in;
    assign ready     = (state == IDLE) && !channel_busy && !reset;
`endif

    assign launch = (state == IDLE) && !channel_busy && have_item;

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = SEND;
                    shreg_nx = frame_of(item);
                    cnt_nx   = '0;
                end
            end
            SEND: begin
                shreg_nx = shreg >> 1;
                cnt_nx   = cnt + 1'b1;
                if (cnt == CNT_W'(TX_SIZE))
                    state_nx = WAIT;
            end
            WAIT: begin
                // Back to IDLE only; a launch needs a further edge.
                if (!channel_busy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    assign serial_out = !reset && (state == SEND) && shreg[0];
    assign tx_busy    = !reset && (state != IDLE);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && launch && routerid >= 0)
            $display("router %0d %s tx : %h", routerid, port, item);
    end
`endif

endmodule
